axi_r_channel_master_mo: RTL and testbench

//  AXI read master. Issues INCR bursts, keeps up to MAX_OUTSTANDING bursts in flight.

---
 rtl/axi_r_channel_master_mo.sv | 188 ++++++++++++++++++
 tb/tb_axi_r_channel_master_mo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/axi_r_channel_master_mo.sv
// AXI read master: INCR bursts, up to MAX_OUTSTANDING in flight, RAW-hazard gated AR, registered R beat reporting.
// Optional error reporting (rdata_err, rd_err_sticky) enabled by defining AXI_RD_ERR_EN.
module axi_r_channel_master_mo #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned LEN_WIDTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [LEN_WIDTH-1:0]  ARLEN,
    output logic [ID_WIDTH-1:0]   ARID,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [ID_WIDTH-1:0]   RID,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [LEN_WIDTH-1:0]  arlen,
    input  logic [ID_WIDTH-1:0]   arid,
    output logic                  raddr_ok,
    input  logic                  mem_writing,
    input  logic [ADDR_WIDTH-1:0] mem_last_write_address,
    output logic                  rdata_ok,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [LEN_WIDTH-1:0]  rdata_ptr,
    output logic                  rdata_last
`ifdef AXI_RD_ERR_EN
    ,
    output logic                  rdata_err,
    output logic                  rd_err_sticky
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {S_IDLE, S_REQ} state_e;

    state_e                state_q, state_d;
    logic                  arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [LEN_WIDTH-1:0]  arlen_q, arlen_d;
    logic [ID_WIDTH-1:0]   arid_q, arid_d;
    logic [CNT_W-1:0]      outst_q, outst_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic                  rdata_ok_q, rdata_ok_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [LEN_WIDTH-1:0]  ptr_q, ptr_d;
    logic                  last_q, last_d;
    logic                  take, ar_hs, r_hs, rlast_hs, hazard;
    logic                  unused_rresp;

    // Hazard only delays the issue; the pending request stays latched.
    assign hazard   = mem_writing && (araddr_q == mem_last_write_address);
    assign ARVALID  = arvalid_q && !hazard;
    assign ar_hs    = ARVALID && ARREADY;
    assign RREADY   = (outst_q != '0);
    assign r_hs     = RVALID && RREADY;
    assign rlast_hs = r_hs && RLAST;
    assign take     = ren && raddr_ok;

    assign ARADDR     = araddr_q;
    assign ARLEN      = arlen_q;
    assign ARID       = arid_q;
    assign ARSIZE     = 3'($clog2(DATA_WIDTH / 8));
    assign ARBURST    = 2'b01;
    assign rdata_ok   = rdata_ok_q;
    assign rdata      = rdata_q;
    assign rid        = rid_q;
    assign rdata_ptr  = ptr_q;
    assign rdata_last = last_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q    <= S_IDLE;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arid_q     <= '0;
            outst_q    <= '0;
            beat_q     <= '0;
            rdata_ok_q <= 1'b0;
            rdata_q    <= '0;
            rid_q      <= '0;
            ptr_q      <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arid_q     <= arid_d;
            outst_q    <= outst_d;
            beat_q     <= beat_d;
            rdata_ok_q <= rdata_ok_d;
            rdata_q    <= rdata_d;
            rid_q      <= rid_d;
            ptr_q      <= ptr_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arid_d    = arid_q;
        unique case (state_q)
            S_IDLE: begin
                if (take) begin
                    state_d   = S_REQ;
                    arvalid_d = 1'b1;
                    araddr_d  = araddr;
                    arlen_d   = arlen;
                    arid_d    = arid;
                end
            end
            S_REQ: begin
                if (ar_hs) begin
                    state_d   = S_IDLE;
                    arvalid_d = 1'b0;
                    araddr_d  = '0;
                    arlen_d   = '0;
                    arid_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        raddr_ok = (state_q == S_IDLE) && (outst_q < CNT_W'(MAX_OUTSTANDING));
    end

    always_comb begin
        outst_d = outst_q;
        if (ar_hs && !rlast_hs) begin
            outst_d = outst_q + 1'b1;
        end else if (!ar_hs && rlast_hs) begin
            outst_d = outst_q - 1'b1;
        end
        beat_d     = beat_q;
        rdata_ok_d = r_hs;
        rdata_d    = rdata_q;
        rid_d      = rid_q;
        ptr_d      = ptr_q;
        last_d     = last_q;
        if (r_hs) begin
            rdata_d = RDATA;
            rid_d   = RID;
            ptr_d   = beat_q;
            last_d  = RLAST;
            beat_d  = RLAST ? '0 : beat_q + 1'b1;
        end
    end

`ifdef AXI_RD_ERR_EN
    logic err_q, sticky_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            err_q    <= r_hs && RRESP[1];
            sticky_q <= sticky_q || (r_hs && RRESP[1]);
        end
    end

    assign rdata_err     = err_q;
    assign rd_err_sticky = sticky_q;
    assign unused_rresp  = RRESP[0];
`else
    assign unused_rresp  = ^RRESP;
`endif

endmodule

// File: tb/tb_axi_r_channel_master_mo.sv
// Randomized bench for axi_r_channel_master_mo against a queue-based AXI read reference model.
// Define AXI_RD_ERR_EN on both files to exercise the error-reporting ports.
module tb_axi_r_channel_master_mo;

    localparam int MAXO = 2;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN, ARID;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID, ARREADY;
    logic [31:0] RDATA;
    logic [3:0]  RID;
    logic [1:0]  RRESP;
    logic        RLAST, RVALID, RREADY;
    logic        ren;
    logic [31:0] araddr;
    logic [3:0]  arlen, arid;
    logic        raddr_ok, mem_writing;
    logic [31:0] mem_last_write_address;
    logic        rdata_ok;
    logic [31:0] rdata;
    logic [3:0]  rid, rdata_ptr;
    logic        rdata_last;
`ifdef AXI_RD_ERR_EN
    logic        rdata_err, rd_err_sticky;
`endif

    axi_r_channel_master_mo #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(4), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RID(RID), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .ren(ren), .araddr(araddr), .arlen(arlen), .arid(arid), .raddr_ok(raddr_ok),
        .mem_writing(mem_writing), .mem_last_write_address(mem_last_write_address),
        .rdata_ok(rdata_ok), .rdata(rdata), .rid(rid), .rdata_ptr(rdata_ptr), .rdata_last(rdata_last)
`ifdef AXI_RD_ERR_EN
        , .rdata_err(rdata_err), .rd_err_sticky(rd_err_sticky)
`endif
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [3:0] id;
        int         len;
    } burst_t;

    // Reference model: one latched request plus a FIFO of issued bursts.
    burst_t      inflight[$];
    bit          pend;
    logic [31:0] p_addr;
    logic [3:0]  p_len, p_id;
    int          bidx;
    logic        m_ok, m_last, m_err, m_sticky;
    logic [31:0] m_data;
    logic [3:0]  m_rid, m_ptr;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        pend     = 1'b0;
        p_addr   = '0;
        p_len    = '0;
        p_id     = '0;
        bidx     = 0;
        m_ok     = 1'b0;
        m_last   = 1'b0;
        m_err    = 1'b0;
        m_sticky = 1'b0;
        m_data   = '0;
        m_rid    = '0;
        m_ptr    = '0;
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(3))
            0: return 32'h100;
            1: return 32'h200;
            2: return 32'h300;
            default: return $urandom;
        endcase
    endfunction

    task automatic step(input int pren, input int parr, input int prv, input int pmw, input int prst);
        logic rst, e_raddr_ok, e_arvalid, e_rready, arhs, rhs, tk;
        @(negedge ACLK);
        check("rdata_ok", 64'(rdata_ok), 64'(m_ok));
        check("rdata", 64'(rdata), 64'(m_data));
        check("rid", 64'(rid), 64'(m_rid));
        check("rdata_ptr", 64'(rdata_ptr), 64'(m_ptr));
        if (m_ok) check("rdata_last", 64'(rdata_last), 64'(m_last));
`ifdef AXI_RD_ERR_EN
        check("rdata_err", 64'(rdata_err), 64'(m_err));
        check("rd_err_sticky", 64'(rd_err_sticky), 64'(m_sticky));
`endif
        rst         = ($urandom_range(999) < prst);
        ARESETn     = !rst;
        ren         = ($urandom_range(99) < pren);
        araddr      = pick_addr();
        arlen       = 4'($urandom_range(3));
        arid        = 4'($urandom);
        ARREADY     = ($urandom_range(99) < parr);
        mem_writing = ($urandom_range(99) < pmw);
        mem_last_write_address = pick_addr();
        RVALID      = ($urandom_range(99) < prv);
        RDATA       = $urandom;
        RRESP       = 2'($urandom_range(3));
        if (inflight.size() != 0) begin
            RID   = inflight[0].id;
            RLAST = (bidx == inflight[0].len);
        end else begin
            RID   = 4'($urandom);
            RLAST = 1'($urandom_range(1));
        end
        #1;
        e_rready   = (inflight.size() != 0);
        e_raddr_ok = !pend && (inflight.size() < MAXO);
        e_arvalid  = pend && !(mem_writing && (p_addr == mem_last_write_address));
        check("raddr_ok", 64'(raddr_ok), 64'(e_raddr_ok));
        check("ARVALID", 64'(ARVALID), 64'(e_arvalid));
        check("RREADY", 64'(RREADY), 64'(e_rready));
        check("ARADDR", 64'(ARADDR), 64'(p_addr));
        check("ARLEN", 64'(ARLEN), 64'(p_len));
        check("ARID", 64'(ARID), 64'(p_id));
        check("ARSIZE", 64'(ARSIZE), 64'd2);
        check("ARBURST", 64'(ARBURST), 64'd1);
        arhs = e_arvalid && ARREADY;
        rhs  = RVALID && e_rready;
        tk   = ren && e_raddr_ok;
        if (rst) begin
            model_reset();
        end else begin
            m_ok  = rhs;
            m_err = rhs && RRESP[1];
            if (rhs) begin
                m_data   = RDATA;
                m_rid    = RID;
                m_ptr    = 4'(bidx);
                m_last   = RLAST;
                m_sticky = m_sticky | RRESP[1];
                if (RLAST) begin
                    void'(inflight.pop_front());
                    bidx = 0;
                end else begin
                    bidx++;
                end
            end
            if (arhs) begin
                inflight.push_back('{id: p_id, len: int'(p_len)});
                pend   = 1'b0;
                p_addr = '0;
                p_len  = '0;
                p_id   = '0;
            end
            if (tk) begin
                pend   = 1'b1;
                p_addr = araddr;
                p_len  = arlen;
                p_id   = arid;
            end
        end
        @(posedge ACLK);
    endtask

    initial begin
        ARESETn = 1'b0;
        ren = 1'b0; araddr = '0; arlen = '0; arid = '0;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RID = '0; RRESP = '0; RLAST = 1'b0;
        mem_writing = 1'b0; mem_last_write_address = '0;
        model_reset();
        @(posedge ACLK);
        repeat (40)   step(30, 100, 100, 0, 0);
        repeat (30)   step(100, 100, 0, 0, 0);
        repeat (30)   step(0, 100, 100, 0, 0);
        repeat (200)  step(60, 100, 100, 60, 0);
        repeat (300)  step(70, 40, 40, 30, 20);
        repeat (1500) step(50, 60, 60, 40, 8);
        repeat (3)    step(0, 0, 0, 0, 1000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
